// File: rtl/ahb_irq_controller_if.sv
// AHB-Lite bus bundle shared by the manager mux and its satellites.
interface ahb_bus_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport satellite (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );

  modport manager (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_irq_controller.sv
// AHB-Lite interrupt controller: per-source gateway (edge/level), priority
// arbitration against a threshold, claim/complete handshake, and a single
// registered request to the core.
// Optional build macro IRQC_SYNC_EN adds a 2-flop synchronizer on every
// irq_in bit ahead of edge detection (source latency +2 cycles).
module ahb_irq_controller #(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               nrst,
  ahb_bus_if.satellite       abif,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] SRC_MASK = {{(NUM_SRC-1){1'b1}}, 1'b0};
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  localparam logic [11:0] ADDR_PENDING   = 12'h400;
  localparam logic [11:0] ADDR_ENABLE    = 12'h404;
  localparam logic [11:0] ADDR_MODE      = 12'h408;
  localparam logic [11:0] ADDR_THRESHOLD = 12'h40C;
  localparam logic [11:0] ADDR_CLAIM     = 12'h410;

  // Registered AHB address phase
  logic        vld_p1;
  logic        write_p1;
  logic [11:0] addr_p1;
  logic [2:0]  size_p1;

  // Controller state
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [PRIO_W-1:0]  threshold;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] line_prev;

  logic [NUM_SRC-1:0] line;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] cmpl_vec;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               rd_claim;
  logic               wr_ok;
  logic [31:0]        rdata;

  // Address bits above the 4 KiB window and the sequential flag are not decoded.
  logic unused_bits;
  assign unused_bits = ^{abif.haddr[31:12], abif.htrans[0]};

`ifdef IRQC_SYNC_EN
  logic [NUM_SRC-1:0] sync_p0;
  logic [NUM_SRC-1:0] sync_p1;

  // Two-flop synchronizer for asynchronous source lines
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
    end
  end

  assign line = sync_p1;
`else
  assign line = irq_in;
`endif

  // Capture the AHB address phase for use in the following data phase
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= '0;
      size_p1  <= '0;
    end else begin
      vld_p1   <= abif.hsel & abif.htrans[1] & abif.hready;
      write_p1 <= abif.hwrite;
      addr_p1  <= abif.haddr[11:0];
      size_p1  <= abif.hsize;
    end
  end

  assign rd_claim = vld_p1 & ~write_p1 & (addr_p1 == ADDR_CLAIM);
  assign wr_ok    = vld_p1 & write_p1 & (size_p1 == 3'b010);

  // Highest priority above threshold wins; strict compare keeps the lowest ID on ties
  always_comb begin
    win_id   = '0;
    win_prio = threshold;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (enable[i] && pending[i] && (prio[i] > win_prio)) begin
        win_id   = ID_W'(i);
        win_prio = prio[i];
      end
    end
  end

  // Gateway set/clear terms: edge sources keep a colliding edge, level sources yield to the claim
  always_comb begin
    edge_det  = line & ~line_prev;
    set_vec   = (mode & edge_det) | (~mode & line & ~in_service);
    claim_vec = (rd_claim && (win_id != '0)) ? (ONE_HOT0 << win_id) : '0;
    cmpl_vec  = '0;
    if (wr_ok && (addr_p1 == ADDR_CLAIM) && (abif.hwdata < 32'(NUM_SRC)))
      cmpl_vec = ONE_HOT0 << abif.hwdata[ID_W-1:0];
  end

  // Pending / in-service bookkeeping and edge-detect history
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pending    <= '0;
      in_service <= '0;
      line_prev  <= '0;
    end else begin
      pending    <= SRC_MASK & ((mode & (set_vec | (pending & ~claim_vec))) |
                                (~mode & ((set_vec | pending) & ~claim_vec)));
      in_service <= SRC_MASK & ((in_service | claim_vec) & ~cmpl_vec);
      line_prev  <= line;
    end
  end

  // Software-visible configuration registers, word writes only
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      mode      <= '0;
      threshold <= '0;
    end else if (wr_ok) begin
      if (addr_p1 == ADDR_ENABLE)    enable    <= abif.hwdata[NUM_SRC-1:0] & SRC_MASK;
      if (addr_p1 == ADDR_MODE)      mode      <= abif.hwdata[NUM_SRC-1:0] & SRC_MASK;
      if (addr_p1 == ADDR_THRESHOLD) threshold <= abif.hwdata[PRIO_W-1:0];
      for (int i = 1; i < NUM_SRC; i++) begin
        if ((addr_p1[11:10] == 2'b00) && (addr_p1[1:0] == 2'b00) && (addr_p1[9:2] == 8'(i)))
          prio[i] <= abif.hwdata[PRIO_W-1:0];
      end
    end
  end

  // Data-phase read mux; unmapped offsets return zero
  always_comb begin
    rdata = '0;
    if (vld_p1 && !write_p1) begin
      case (addr_p1)
        ADDR_PENDING:   rdata = 32'(pending);
        ADDR_ENABLE:    rdata = 32'(enable);
        ADDR_MODE:      rdata = 32'(mode);
        ADDR_THRESHOLD: rdata = 32'(threshold);
        ADDR_CLAIM:     rdata = 32'(win_id);
        default: begin
          for (int i = 1; i < NUM_SRC; i++) begin
            if ((addr_p1[11:10] == 2'b00) && (addr_p1[1:0] == 2'b00) && (addr_p1[9:2] == 8'(i)))
              rdata = 32'(prio[i]);
          end
        end
      endcase
    end
  end

  // Registered request to the core
  always_ff @(posedge clk) begin
    if (!nrst) irq_out <= 1'b0;
    else       irq_out <= (win_id != '0);
  end

  assign abif.hrdata    = rdata;
  assign abif.hreadyout = 1'b1;
  assign abif.hresp     = 1'b0;

endmodule

// File: tb/tb_ahb_irq_controller.sv
// Scoreboard bench for ahb_irq_controller: directed scenarios plus random
// bus/source traffic checked against a behavioural model of the controller.
module tb_ahb_irq_controller;
  localparam int N  = 32;
  localparam int PW = 3;
`ifdef IRQC_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam bit [31:0] SMASK = (N == 32) ? 32'hFFFF_FFFE : (((32'h1 << N) - 1) & ~32'h1);
  localparam bit [31:0] PMASK = (32'h1 << PW) - 1;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] irq_in;
  logic         irq_out;

  ahb_bus_if bus ();

  ahb_irq_controller #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .abif    (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int        m_prio [N];
  bit [31:0] m_en, m_mode, m_pend, m_isv, m_prev;
  int        m_thr;
  bit        m_irq;
  bit [31:0] hist [$];

  // Outstanding transfer whose data phase is in progress
  bit        dp_v, dp_w;
  bit [11:0] dp_a;
  bit [2:0]  dp_sz;
  bit        rd_phase = 1'b0;
  bit        mon_en   = 1'b0;
  bit        force_v  = 1'b0;
  bit [31:0] force_val;
  bit [31:0] wd_next = '0;

  bit [31:0] exp_q  [$];
  string     name_q [$];

  function automatic int winner();
    int best = 0;
    int bp   = m_thr;
    for (int i = 1; i < N; i++)
      if (m_en[i] && m_pend[i] && (m_prio[i] > bp)) begin
        best = i;
        bp   = m_prio[i];
      end
    return best;
  endfunction

  function automatic bit [31:0] mread(bit [11:0] a);
    int idx = int'(a) / 4;
    case (a)
      12'h400: return m_pend;
      12'h404: return m_en;
      12'h408: return m_mode;
      12'h40C: return 32'(m_thr);
      12'h410: return 32'(winner());
      default: begin
        if (a < 12'h400 && a[1:0] == 2'b00 && idx >= 1 && idx < N) return 32'(m_prio[idx]);
        return 32'h0;
      end
    endcase
  endfunction

  // Apply the rules of one clock edge to the model, using inputs present at that edge
  task automatic model_edge();
    int        win;
    bit [31:0] line, edg, d;
    bit        claimed;
    if (!nrst) begin
      foreach (m_prio[i]) m_prio[i] = 0;
      m_en = 0; m_mode = 0; m_pend = 0; m_isv = 0; m_thr = 0; m_irq = 0; m_prev = 0;
      hist.delete();
      repeat (SYNC_D) hist.push_back(32'h0);
      dp_v = 0;
      rd_phase = 0;
      return;
    end
    win = winner();
    hist.push_back(32'(irq_in));
    line = hist.pop_front();
    edg  = line & ~m_prev;
    for (int i = 1; i < N; i++) begin
      claimed = dp_v && !dp_w && (dp_a == 12'h410) && (win == i);
      if (m_mode[i]) m_pend[i] = edg[i] | (m_pend[i] & !claimed);
      else           m_pend[i] = (m_pend[i] | (line[i] & !m_isv[i])) & !claimed;
      if (claimed) m_isv[i] = 1'b1;
    end
    if (dp_v && dp_w && dp_sz == 3'd2) begin
      d = bus.hwdata;
      case (dp_a)
        12'h404: m_en   = d & SMASK;
        12'h408: m_mode = d & SMASK;
        12'h40C: m_thr  = int'(d & PMASK);
        12'h410: if (d < N && d != 0) m_isv[d] = 1'b0;
        default:
          if (dp_a < 12'h400 && dp_a[1:0] == 2'b00 && (dp_a >> 2) >= 1 && (dp_a >> 2) < N)
            m_prio[dp_a >> 2] = int'(d & PMASK);
      endcase
    end
    m_prev = line;
    m_irq  = (win != 0);
    dp_v   = bus.hsel && bus.htrans[1] && bus.hready;
    dp_w   = bus.hwrite;
    dp_a   = bus.haddr[11:0];
    dp_sz  = bus.hsize;
    rd_phase = dp_v && !dp_w;
    if (rd_phase) begin
      exp_q.push_back(force_v ? force_val : mread(dp_a));
      name_q.push_back($sformatf("read 0x%03h", dp_a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic xfer(bit w, bit [11:0] a, bit [31:0] d, bit [2:0] sz);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hready = 1'b1;
    bus.hwrite = w;
    bus.haddr  = {20'($urandom), a};
    bus.hsize  = sz;
    bus.hwdata = wd_next;
    tick();
    wd_next = d;
  endtask

  task automatic wr(bit [11:0] a, bit [31:0] d);
    xfer(1'b1, a, d, 3'd2);
  endtask

  task automatic rd(bit [11:0] a);
    xfer(1'b0, a, 32'h0, 3'd2);
  endtask

  task automatic rd_c(bit [11:0] a, bit [31:0] e);
    force_v = 1'b1;
    force_val = e;
    rd(a);
    force_v = 1'b0;
  endtask

  task automatic idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hready = 1'b1;
    bus.hwdata = wd_next;
    tick();
  endtask

  task automatic pulse(int src);
    irq_in[src] = 1'b1;
    idle();
    irq_in[src] = 1'b0;
    idle();
  endtask

  // Monitor: request line every cycle, read data whenever a read data phase is presented
  always @(negedge clk) begin
    bit [31:0] e;
    string     nm;
    if (mon_en) begin
      n_tests++;
      if (irq_out !== m_irq) begin
        n_fail++;
        $display("FAIL irq_out @%0t: got %b, expected %b", $time, irq_out, m_irq);
      end
      if (rd_phase) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: read data phase with no expected entry", $time);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (bus.hrdata !== e || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
            n_fail++;
            $display("FAIL %s @%0t: hrdata=0x%08h rdy=%b resp=%b, expected 0x%08h rdy=1 resp=0",
                     nm, $time, bus.hrdata, bus.hreadyout, bus.hresp, e);
          end
        end
      end
    end
  end

  initial begin
    bit [11:0] a;
    bit [31:0] d;
    bit [2:0]  sz;
    int        pick;

    nrst = 1'b0;
    irq_in = '0;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hready = 1'b1; bus.hwrite = 1'b0;
    bus.haddr = '0; bus.hsize = 3'd2; bus.hwdata = '0;
    tick();
    mon_en = 1'b1;
    tick();
    nrst = 1'b1;

    n_tests++;
    if (bus.hrdata !== 32'h0 || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: hrdata=0x%08h rdy=%b resp=%b irq=%b, expected 0 1 0 0",
               bus.hrdata, bus.hreadyout, bus.hresp, irq_out);
    end

    // Every register reads zero after reset, including unmapped offsets
    for (int i = 0; i < N; i++) rd_c(12'(4 * i), 32'h0);
    rd_c(12'h400, 0); rd_c(12'h404, 0); rd_c(12'h408, 0); rd_c(12'h40C, 0);
    rd_c(12'h410, 0); rd_c(12'h414, 0); rd_c(12'hFFC, 0);

    // Source 5 edge: pulse, claim, complete
    wr(12'h014, 3); wr(12'h404, 32'h20); wr(12'h408, 32'h20); wr(12'h40C, 0);
    rd_c(12'h014, 3);
    idle();
    pulse(5);
    repeat (SYNC_D + 1) idle();
    rd_c(12'h410, 5);
    rd_c(12'h400, 0);
    idle(); idle();
    wr(12'h410, 5);
    idle();

    // Sources 3 and 7, equal priority then raised priority on 7
    wr(12'h00C, 2); wr(12'h01C, 2); wr(12'h404, 32'hA8); wr(12'h408, 32'hA8);
    idle();
    irq_in[3] = 1'b1; irq_in[7] = 1'b1;
    idle();
    irq_in[3] = 1'b0; irq_in[7] = 1'b0;
    repeat (SYNC_D + 2) idle();
    rd_c(12'h400, 32'h88);
    rd_c(12'h410, 3);
    wr(12'h01C, 4);
    rd_c(12'h410, 7);
    wr(12'h410, 3); wr(12'h410, 7);
    idle();

    // Level source 2
    wr(12'h008, 1); wr(12'h404, 32'hAC);
    irq_in[2] = 1'b1;
    repeat (SYNC_D + 2) idle();
    rd_c(12'h410, 2);
    rd_c(12'h400, 0);
    idle();
    wr(12'h410, 2);
    idle(); idle(); idle();
    rd_c(12'h400, 32'h4);
    wr(12'h40C, 1);
    idle(); idle();
    rd_c(12'h410, 0);
    irq_in[2] = 1'b0;
    wr(12'h40C, 0);
    idle(); idle();
    rd_c(12'h410, 2);
    wr(12'h410, 2);
    repeat (SYNC_D + 2) idle();
    rd_c(12'h400, 0);

    // Edge source 4 re-asserting in the claim data phase
    wr(12'h010, 2); wr(12'h404, 32'hBC); wr(12'h408, 32'hB8);
    idle();
    pulse(4);
    repeat (SYNC_D + 2) idle();
    if (SYNC_D > 0) begin
      irq_in[4] = 1'b1;
      repeat (SYNC_D - 1) idle();
    end
    rd_c(12'h410, 4);
    irq_in[4] = 1'b1;
    rd_c(12'h400, 32'h10);
    irq_in[4] = 1'b0;
    wr(12'h410, 9);
    idle();
    rd_c(12'h400, 32'h10);
    rd_c(12'h410, 4);
    wr(12'h410, 4);
    idle();
    rd_c(12'h400, 0);
    wr(12'h408, 32'hFFFF_FFFF);
    rd_c(12'h408, SMASK);

    // Randomised traffic against the model
    for (int it = 0; it < 4000; it++) begin
      irq_in = irq_in ^ N'($urandom & $urandom & $urandom & $urandom);
      pick = $urandom_range(0, 99);
      if (pick < 2) begin
        nrst = 1'b0;
        idle();
        nrst = 1'b1;
      end else if (pick < 30) begin
        bus.hsel   = 1'($urandom);
        bus.htrans = 2'b10;
        bus.hready = (bus.hsel == 1'b1) ? 1'b0 : 1'b1;
        bus.hwrite = 1'($urandom);
        bus.haddr  = 32'h410;
        bus.hwdata = wd_next;
        tick();
      end else begin
        case ($urandom_range(0, 7))
          0, 1: a = 12'(4 * $urandom_range(0, N));
          2:    a = 12'h400;
          3:    a = 12'h404;
          4:    a = 12'h408;
          5:    a = 12'h40C;
          6:    a = ($urandom_range(0, 3) == 0) ? 12'(12'h414 + 4 * $urandom_range(0, 200)) : 12'h410;
          default: a = 12'h410;
        endcase
        if (pick < 60) begin
          d  = $urandom;
          if (a == 12'h40C && $urandom_range(0, 1) == 1) d = $urandom_range(0, 3);
          if (a == 12'h410) begin
            d = $urandom_range(0, 40);
            if (m_isv != 0 && $urandom_range(0, 3) != 0) begin
              int s = $urandom_range(1, N - 1);
              for (int k = 0; k < N; k++) begin
                if (m_isv[(s + k) % N]) begin
                  d = 32'((s + k) % N);
                  break;
                end
              end
            end
          end
          sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
          xfer(1'b1, a, d, sz);
        end else begin
          rd(a);
        end
      end
    end

    idle(); idle(); idle();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
